reg_wb_ctrl: RTL and testbench
==============================

// Module: reg_wb_ctrl
// PURPOSE
//  Write-back controller: the writer side of the 32-bit register file. Accepts results from
//  the ALU and memory (load) paths via valid/ready, queues them in order, and drains one
//  register write per cycle onto the file's we/wa/wd port. Writes to r15 go to the PC.
//  Provides operand forwarding for pending writes and a PC-write-pending flag for fetch.
// PARAMETERS
//  DEPTH  4   queue entries; power of two, >=2
//  DW     32  data width
//  AW     4   register address width (r0..r15)
// PORTS
//  clk          in   1    clock, rising edge
//  reset        in   1    asynchronous, active-high
//  alu_valid    in   1    ALU result valid
//  alu_ready    out  1    ALU result accepted this edge when valid&ready
//  alu_addr     in   AW   destination register
//  alu_data     in   DW   result
//  mem_valid    in   1    load result valid (older than same-cycle ALU result)
//  mem_ready    out  1    load result accepted when valid&ready
//  mem_addr     in   AW   destination register
//  mem_data     in   DW   loaded word
//  mem_byte     in   1    LDRB: byte load (used only with WB_LDRB_EN)
//  mem_boff     in   2    byte offset within word (used only with WB_LDRB_EN)
//  wb_stall     in   1    hold drain (register file busy)
//  we/wa/wd     out  1/AW/DW  register-file write port, registered
//  rd1_addr     in   AW   operand-1 read address;  rd2_addr in AW operand-2 read address
//  fwd1_hit/fwd1_data  out 1/DW  newest pending write to rd1_addr (combinational)
//  fwd2_hit/fwd2_data  out 1/DW  same for rd2_addr
//  pc_pending   out  1    any queued or in-flight entry targets r15
//  count        out  $clog2(DEPTH)+1  queue occupancy
// BEHAVIOUR
//  - Reset (async): queue empty, pointers 0, we=0, wa=0, wd=0, count=0; all fwd_hit=0, pc_pending=0.
//  - Pop: at each edge, if count>0 and !wb_stall, head loads into we/wa/wd with we=1; else we=0.
//    Latency: accepted at edge N -> we=1 during cycle after edge N+1 (empty queue, no stall).
//  - free = DEPTH-count+pop. mem_ready=(free>=1). alu_ready=(free>=2)|(free>=1 & !mem_valid).
//  - Both accepted same edge: mem entry enqueued first, then ALU (program order preserved).
//  - Full with pop in same cycle: one slot is reusable that edge (free counts the pop).
//  - Pointers wrap modulo DEPTH; count never exceeds DEPTH nor underflows.
//  - Forwarding: search output reg (oldest) then queue head..tail; youngest match wins;
//    r15 included; no match -> hit=0, data=0. Queue contents only; same-edge inputs not seen.
//  - pc_pending = OR over valid entries and (we & wa==15).
//  - wb_stall holds we=0 and queue unchanged except enqueues.
//  - Reset mid-drain: pending writes discarded, we drops to 0 without waiting for clk.
// CONFIGURATION
//  WB_LDRB_EN defined: when mem_byte=1, enqueued data = zero-extended byte lane of mem_data,
//   lane 0 = bits 31:24 (MSB-first byte order of the register file), lane 3 = bits 7:0.
//  WB_LDRB_EN undefined: mem_byte/mem_boff ignored; mem_data enqueued unchanged.
// STRUCTURE
//  Shared include wb_defs.vh: `define REG_PC 4'd15, entry layout {addr,data}, width constants.
//  Sub-module wb_fifo (DEPTH x {AW+DW}, push-two/pop-one, exposes all entries + valid mask
//  for the forwarding search). Top holds ready logic, output register, forward/priority mux.
// TESTING
//  1 reset mid-run with 3 queued -> we=0 asynchronously, count=0, pc_pending=0, hits=0.
//  2 alu (r3,0x11) alone, empty queue -> we=1 wa=3 wd=0x11 two edges later; count 1 then 0.
//  3 mem (r2,0xA) + alu (r2,0xB) same edge -> writes r2=0xA then r2=0xB; fwd on r2 = 0xB.
//  4 wb_stall=1, push 4 -> count=4, both ready=0; release -> one write per cycle in order.
//  5 alu to r15 -> pc_pending=1 until the write cycle ends; we=1 wa=15.
//  6 WB_LDRB_EN, mem_byte=1 boff=1 data 0x12345678 -> wd=0x00000034; undefined -> 0x12345678.

Source files
------------

// File: rtl/reg_wb_ctrl_pkg.sv
// Shared constants for the register-file write-back controller.
package reg_wb_ctrl_pkg;

  // Architectural PC register index (r15).
  localparam int REG_PC = 15;

  // Width of one byte lane for byte loads.
  localparam int BYTE_W = 8;

endpackage

// File: rtl/reg_wb_ctrl_fifo.sv
// In-order write-back queue: push up to two entries per edge (d0 first, then d1),
// pop one. Exposes every entry in age order with a valid mask for the forwarding search.
module reg_wb_ctrl_fifo
  import reg_wb_ctrl_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 36
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push0,
  input  logic                     push1,
  input  logic [W-1:0]             d0,
  input  logic [W-1:0]             d1,
  input  logic                     pop,
  output logic [$clog2(DEPTH):0]   count,
  output logic [W-1:0]             head,
  output logic [W-1:0]             ent_age [DEPTH],
  output logic [DEPTH-1:0]         vld_age
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wp, rp;

  // Entry storage; push1 is only ever asserted together with push0.
  always_ff @(posedge clk) begin
    if (push0) mem[wp] <= d0;
    if (push1) mem[wp + PW'(1)] <= d1;
  end

  // Pointers wrap naturally at DEPTH (power of two); top guarantees no over/underflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      wp    <= wp + PW'(push0) + PW'(push1);
      rp    <= rp + PW'(pop);
      count <= count + CW'(push0) + CW'(push1) - CW'(pop);
    end
  end

  assign head = mem[rp];

  // Rotate storage into oldest-first order for the forwarding search.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_age[i] = mem[rp + PW'(i)];
      vld_age[i] = CW'(i) < count;
    end
  end

endmodule

// File: rtl/reg_wb_ctrl.sv
// Write-back controller: queues ALU and load results in program order and drains
// one register-file write per cycle. Provides operand forwarding and PC-write-pending.
// Optional feature macro: WB_LDRB_EN (byte-load lane extraction on the mem path).
module reg_wb_ctrl
  import reg_wb_ctrl_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DW    = 32,
  parameter int AW    = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   alu_valid,
  output logic                   alu_ready,
  input  logic [AW-1:0]          alu_addr,
  input  logic [DW-1:0]          alu_data,
  input  logic                   mem_valid,
  output logic                   mem_ready,
  input  logic [AW-1:0]          mem_addr,
  input  logic [DW-1:0]          mem_data,
  input  logic                   mem_byte,
  input  logic [1:0]             mem_boff,
  input  logic                   wb_stall,
  output logic                   we,
  output logic [AW-1:0]          wa,
  output logic [DW-1:0]          wd,
  input  logic [AW-1:0]          rd1_addr,
  input  logic [AW-1:0]          rd2_addr,
  output logic                   fwd1_hit,
  output logic [DW-1:0]          fwd1_data,
  output logic                   fwd2_hit,
  output logic [DW-1:0]          fwd2_data,
  output logic                   pc_pending,
  output logic [$clog2(DEPTH):0] count
);

  localparam int EW = AW + DW;
  localparam int CW = $clog2(DEPTH) + 1;

  logic          pop;
  logic [CW:0]   free;
  logic          mem_acc, alu_acc, push0, push1;
  logic [DW-1:0] mem_wdata;
  logic [EW-1:0] d0, d1, head;
  logic [EW-1:0] ent_age [DEPTH];
  logic [DEPTH-1:0] vld_age;

  assign pop  = (count != '0) && !wb_stall;
  // A slot drained this edge is reusable this edge.
  assign free = (CW+1)'(DEPTH) - {1'b0, count} + (CW+1)'(pop);

  // Load is older than a same-cycle ALU result, so it claims the last slot.
  assign mem_ready = (free != '0);
  assign alu_ready = (free > (CW+1)'(1)) | (mem_ready & !mem_valid);

`ifdef WB_LDRB_EN
  logic [BYTE_W-1:0] lane;

  // Byte lane 0 is the most significant byte of the word.
  always_comb begin
    case (mem_boff)
      2'd0:    lane = mem_data[DW-1  -: BYTE_W];
      2'd1:    lane = mem_data[DW-9  -: BYTE_W];
      2'd2:    lane = mem_data[DW-17 -: BYTE_W];
      default: lane = mem_data[DW-25 -: BYTE_W];
    endcase
  end

  assign mem_wdata = mem_byte ? {{(DW-BYTE_W){1'b0}}, lane} : mem_data;
`else
  logic unused_ldrb;
  assign unused_ldrb = ^{mem_byte, mem_boff};
  assign mem_wdata   = mem_data;
`endif

  assign mem_acc = mem_valid & mem_ready;
  assign alu_acc = alu_valid & alu_ready;
  assign push0   = mem_acc | alu_acc;
  assign push1   = mem_acc & alu_acc;
  assign d0      = mem_acc ? {mem_addr, mem_wdata} : {alu_addr, alu_data};
  assign d1      = {alu_addr, alu_data};

  reg_wb_ctrl_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push0   (push0),
    .push1   (push1),
    .d0      (d0),
    .d1      (d1),
    .pop     (pop),
    .count   (count),
    .head    (head),
    .ent_age (ent_age),
    .vld_age (vld_age)
  );

  // Register-file write port: load the queue head whenever draining.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we <= 1'b0;
      wa <= '0;
      wd <= '0;
    end else begin
      we <= pop;
      if (pop) {wa, wd} <= head;
    end
  end

  // Forwarding: output reg is oldest, then queue oldest->youngest; last match wins.
  always_comb begin
    fwd1_hit   = we && (wa == rd1_addr);
    fwd1_data  = fwd1_hit ? wd : '0;
    fwd2_hit   = we && (wa == rd2_addr);
    fwd2_data  = fwd2_hit ? wd : '0;
    pc_pending = we && (wa == AW'(REG_PC));
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_age[i]) begin
        if (ent_age[i][EW-1 -: AW] == rd1_addr) begin
          fwd1_hit  = 1'b1;
          fwd1_data = ent_age[i][DW-1:0];
        end
        if (ent_age[i][EW-1 -: AW] == rd2_addr) begin
          fwd2_hit  = 1'b1;
          fwd2_data = ent_age[i][DW-1:0];
        end
        if (ent_age[i][EW-1 -: AW] == AW'(REG_PC)) pc_pending = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_reg_wb_ctrl.sv
// Self-checking bench for reg_wb_ctrl: directed scenarios plus random traffic
// against a queue-based reference model.
module tb_reg_wb_ctrl;

  localparam int DEPTH = 4;
  localparam int DW    = 32;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          alu_valid = 0, mem_valid = 0, mem_byte = 0, wb_stall = 0;
  logic [AW-1:0] alu_addr = 0, mem_addr = 0, rd1_addr = 0, rd2_addr = 0;
  logic [DW-1:0] alu_data = 0, mem_data = 0;
  logic [1:0]    mem_boff = 0;
  logic          alu_ready, mem_ready, we, fwd1_hit, fwd2_hit, pc_pending;
  logic [AW-1:0] wa;
  logic [DW-1:0] wd, fwd1_data, fwd2_data;
  logic [$clog2(DEPTH):0] count;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } ent_t;
  ent_t          q[$];
  logic          m_we = 0;
  logic [AW-1:0] m_wa = 0;
  logic [DW-1:0] m_wd = 0;

  reg_wb_ctrl #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_byte(mem_byte), .mem_boff(mem_boff), .wb_stall(wb_stall),
    .we(we), .wa(wa), .wd(wd), .rd1_addr(rd1_addr), .rd2_addr(rd2_addr),
    .fwd1_hit(fwd1_hit), .fwd1_data(fwd1_data), .fwd2_hit(fwd2_hit), .fwd2_data(fwd2_data),
    .pc_pending(pc_pending), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] load_val(input logic [DW-1:0] d, input logic b,
                                              input logic [1:0] o);
    bit en = 0;
`ifdef WB_LDRB_EN
    en = 1;
`endif
    if (en && b) return (d >> (8 * (3 - int'(o)))) & 32'hFF;
    return d;
  endfunction

  // Compare every observable output against the model's current state.
  task automatic check_all();
    bit h1 = 0, h2 = 0, pc = 0, pop;
    logic [DW-1:0] f1 = 0, f2 = 0;
    int free;
    pop  = (q.size() > 0) && !wb_stall;
    free = DEPTH - q.size() + int'(pop);
    if (m_we) begin
      if (m_wa == rd1_addr) begin h1 = 1; f1 = m_wd; end
      if (m_wa == rd2_addr) begin h2 = 1; f2 = m_wd; end
      if (m_wa == 15) pc = 1;
    end
    foreach (q[i]) begin
      if (q[i].a == rd1_addr) begin h1 = 1; f1 = q[i].d; end
      if (q[i].a == rd2_addr) begin h2 = 1; f2 = q[i].d; end
      if (q[i].a == 15) pc = 1;
    end
    chk("we", we, m_we);
    chk("wa", wa, m_wa);
    chk("wd", wd, m_wd);
    chk("count", count, q.size());
    chk("mem_ready", mem_ready, free >= 1);
    chk("alu_ready", alu_ready, (free >= 2) || (free >= 1 && !mem_valid));
    chk("fwd1_hit", fwd1_hit, h1);
    chk("fwd1_data", fwd1_data, f1);
    chk("fwd2_hit", fwd2_hit, h2);
    chk("fwd2_data", fwd2_data, f2);
    chk("pc_pending", pc_pending, pc);
  endtask

  // Advance the model across one rising edge using the currently driven inputs.
  task automatic model_edge();
    bit pop, mr, ar;
    int free;
    ent_t e;
    pop  = (q.size() > 0) && !wb_stall;
    free = DEPTH - q.size() + int'(pop);
    mr   = free >= 1;
    ar   = (free >= 2) || (free >= 1 && !mem_valid);
    if (pop) begin
      e = q.pop_front();
      m_we = 1; m_wa = e.a; m_wd = e.d;
    end else begin
      m_we = 0;
    end
    if (mem_valid && mr) q.push_back('{mem_addr, load_val(mem_data, mem_byte, mem_boff)});
    if (alu_valid && ar) q.push_back('{alu_addr, alu_data});
  endtask

  task automatic step(input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                      input logic mv, input logic [AW-1:0] ma, input logic [DW-1:0] md,
                      input logic mb, input logic [1:0] mo, input logic st,
                      input logic [AW-1:0] r1, input logic [AW-1:0] r2);
    alu_valid = av; alu_addr = aa; alu_data = ad;
    mem_valid = mv; mem_addr = ma; mem_data = md; mem_byte = mb; mem_boff = mo;
    wb_stall = st; rd1_addr = r1; rd2_addr = r2;
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle(input logic st, input logic [AW-1:0] r1, input logic [AW-1:0] r2);
    step(0, 0, 0, 0, 0, 0, 0, 0, st, r1, r2);
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_we", we, 0);
    chk("rst_wa", wa, 0);
    chk("rst_wd", wd, 0);
    chk("rst_count", count, 0);
    chk("rst_pc_pending", pc_pending, 0);
    chk("rst_fwd1_hit", fwd1_hit, 0);
    reset = 1'b0;
    #4;

    // Single ALU result through an empty queue
    step(1, 4'd3, 32'h11, 0, 0, 0, 0, 0, 0, 4'd3, 4'd0);
    idle(0, 4'd3, 4'd0);
    idle(0, 4'd3, 4'd0);
    chk("alu_only_wd", wd, 32'h11);

    // Same-edge load + ALU to the same register: load first, ALU result forwarded
    step(1, 4'd2, 32'hB, 1, 4'd2, 32'hA, 0, 0, 0, 4'd2, 4'd2);
    idle(0, 4'd2, 4'd0);
    chk("order_fwd", fwd1_data, 32'hB);
    idle(0, 4'd2, 4'd0);
    idle(0, 4'd2, 4'd0);

    // Fill under stall, confirm back-pressure, then drain in order
    for (int i = 0; i < 4; i++) step(1, 4'(i + 4), 32'h100 + i, 0, 0, 0, 0, 0, 1, 4'd5, 4'd6);
    chk("full_count", count, DEPTH);
    step(1, 4'd9, 32'hDEAD, 1, 4'd8, 32'hBEEF, 0, 0, 1, 4'd5, 4'd6);
    // Full with drain: one slot reusable, load takes it
    step(1, 4'd9, 32'hDEAD, 1, 4'd8, 32'hBEEF, 0, 0, 0, 4'd8, 4'd9);
    for (int i = 0; i < 6; i++) idle(0, 4'd8, 4'd4);

    // Write to PC
    step(1, 4'd15, 32'h800, 0, 0, 0, 0, 0, 0, 4'd15, 4'd1);
    idle(0, 4'd15, 4'd1);
    idle(0, 4'd15, 4'd1);
    idle(0, 4'd15, 4'd1);

    // Byte load, lane 1
    step(0, 0, 0, 1, 4'd5, 32'h12345678, 1, 2'd1, 0, 4'd5, 4'd0);
    idle(0, 4'd5, 4'd0);
`ifdef WB_LDRB_EN
    chk("ldrb_wd", wd, 32'h34);
`else
    chk("ldrb_wd", wd, 32'h12345678);
`endif
    idle(0, 4'd5, 4'd0);

    // Asynchronous reset in the middle of a drain
    step(1, 4'd15, 32'h1, 0, 0, 0, 0, 0, 1, 4'd7, 4'd9);
    step(1, 4'd7, 32'h2, 0, 0, 0, 0, 0, 1, 4'd7, 4'd9);
    step(1, 4'd9, 32'h3, 0, 0, 0, 0, 0, 1, 4'd7, 4'd9);
    idle(0, 4'd7, 4'd9);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_we", we, 0);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_pc_pending", pc_pending, 0);
    chk("mid_rst_fwd1_hit", fwd1_hit, 0);
    chk("mid_rst_fwd2_hit", fwd2_hit, 0);
    q.delete();
    m_we = 0; m_wa = 0; m_wd = 0;
    reset = 1'b0;

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      step(logic'($urandom_range(1, 0)), 4'($urandom_range(15, 0)), $urandom,
           logic'($urandom_range(1, 0)), 4'($urandom_range(15, 0)), $urandom,
           logic'($urandom_range(1, 0)), 2'($urandom_range(3, 0)),
           logic'($urandom_range(3, 0) == 0),
           4'($urandom_range(15, 0)), 4'($urandom_range(15, 0)));
    end
    for (int i = 0; i < 6; i++) idle(0, 4'd15, 4'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
